// File: rtl/datapath_sequencer.sv
// datapath_sequencer: multi-cycle controller driving register-file/ALU datapath control lines.
// Optional one-entry command buffer enabled by defining DATAPATH_SEQ_CMDBUF_EN.
`default_nettype none

module datapath_sequencer #(
   parameter int DATA_W  = 16,
   parameter int RADDR_W = 3
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [2:0]         cmd_op,
   input  logic [RADDR_W-1:0] cmd_rd,
   input  logic [RADDR_W-1:0] cmd_rn,
   input  logic [RADDR_W-1:0] cmd_rm,
   input  logic [1:0]         cmd_sh,
   input  logic [DATA_W-1:0]  cmd_imm,
   output logic               done,
   output logic               err,
   output logic [DATA_W-1:0]  datapath_in,
   output logic [RADDR_W-1:0] writenum,
   output logic [RADDR_W-1:0] readnum,
   output logic               write,
   output logic               vsel,
   output logic               asel,
   output logic               bsel,
   output logic               loada,
   output logic               loadb,
   output logic               loadc,
   output logic               loads,
   output logic [1:0]         ALUop,
   output logic [1:0]         shift
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_GETA = 3'd1;
   localparam logic [2:0] S_GETB = 3'd2;
   localparam logic [2:0] S_EXEC = 3'd3;
   localparam logic [2:0] S_WIMM = 3'd4;
   localparam logic [2:0] S_WREG = 3'd5;
   localparam logic [2:0] S_ERR  = 3'd6;

   localparam logic [2:0] OP_MOVI = 3'b000;
   localparam logic [2:0] OP_MOVS = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_CMP  = 3'b011;
   localparam logic [2:0] OP_AND  = 3'b100;
   localparam logic [2:0] OP_MVN  = 3'b101;

   logic [2:0]         state;
   logic [2:0]         cur_op;
   logic [RADDR_W-1:0] cur_rd;
   logic [RADDR_W-1:0] cur_rn;
   logic [RADDR_W-1:0] cur_rm;
   logic [1:0]         cur_sh;

   // Command presented to the FSM this cycle (from the port or the buffer)
   logic               launch;
   logic [2:0]         new_op;
   logic [RADDR_W-1:0] new_rd;
   logic [RADDR_W-1:0] new_rn;
   logic [RADDR_W-1:0] new_rm;
   logic [1:0]         new_sh;
   logic [DATA_W-1:0]  new_imm;

`ifdef DATAPATH_SEQ_CMDBUF_EN
   logic               buf_valid;
   logic [2:0]         buf_op;
   logic [RADDR_W-1:0] buf_rd;
   logic [RADDR_W-1:0] buf_rn;
   logic [RADDR_W-1:0] buf_rm;
   logic [1:0]         buf_sh;
   logic [DATA_W-1:0]  buf_imm;
   logic               take;

   assign cmd_ready = ~buf_valid;
   assign take      = cmd_valid & cmd_ready;
   assign launch    = (state == S_IDLE) & (buf_valid | take);
   assign new_op    = buf_valid ? buf_op  : cmd_op;
   assign new_rd    = buf_valid ? buf_rd  : cmd_rd;
   assign new_rn    = buf_valid ? buf_rn  : cmd_rn;
   assign new_rm    = buf_valid ? buf_rm  : cmd_rm;
   assign new_sh    = buf_valid ? buf_sh  : cmd_sh;
   assign new_imm   = buf_valid ? buf_imm : cmd_imm;

   // An idle accept with an empty buffer bypasses straight into the FSM
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         buf_valid <= 1'b0;
         buf_op    <= '0;
         buf_rd    <= '0;
         buf_rn    <= '0;
         buf_rm    <= '0;
         buf_sh    <= '0;
         buf_imm   <= '0;
      end else if (launch && buf_valid) begin
         buf_valid <= 1'b0;
      end else if (take && state != S_IDLE) begin
         buf_valid <= 1'b1;
         buf_op    <= cmd_op;
         buf_rd    <= cmd_rd;
         buf_rn    <= cmd_rn;
         buf_rm    <= cmd_rm;
         buf_sh    <= cmd_sh;
         buf_imm   <= cmd_imm;
      end
   end
`else
   assign cmd_ready = (state == S_IDLE);
   assign launch    = cmd_valid & cmd_ready;
   assign new_op    = cmd_op;
   assign new_rd    = cmd_rd;
   assign new_rn    = cmd_rn;
   assign new_rm    = cmd_rm;
   assign new_sh    = cmd_sh;
   assign new_imm   = cmd_imm;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= S_IDLE;
         cur_op      <= '0;
         cur_rd      <= '0;
         cur_rn      <= '0;
         cur_rm      <= '0;
         cur_sh      <= '0;
         datapath_in <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (launch) begin
                  cur_op      <= new_op;
                  cur_rd      <= new_rd;
                  cur_rn      <= new_rn;
                  cur_rm      <= new_rm;
                  cur_sh      <= new_sh;
                  datapath_in <= new_imm;
                  case (new_op)
                     OP_MOVI:                state <= S_WIMM;
                     OP_MOVS, OP_MVN:        state <= S_GETB;
                     OP_ADD, OP_CMP, OP_AND: state <= S_GETA;
                     default:                state <= S_ERR;
                  endcase
               end
            end
            S_GETA:  state <= S_GETB;
            S_GETB:  state <= S_EXEC;
            S_EXEC:  state <= (cur_op == OP_CMP) ? S_IDLE : S_WREG;
            default: state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      done     = 1'b0;
      err      = 1'b0;
      writenum = '0;
      readnum  = '0;
      write    = 1'b0;
      vsel     = 1'b0;
      asel     = 1'b0;
      bsel     = 1'b0;
      loada    = 1'b0;
      loadb    = 1'b0;
      loadc    = 1'b0;
      loads    = 1'b0;
      ALUop    = 2'b00;
      shift    = 2'b00;
      case (state)
         S_GETA: begin
            readnum = cur_rn;
            loada   = 1'b1;
         end
         S_GETB: begin
            readnum = cur_rm;
            loadb   = 1'b1;
         end
         S_EXEC: begin
            loadc = 1'b1;
            loads = 1'b1;
            shift = cur_sh;
            case (cur_op)
               OP_CMP:  ALUop = 2'b01;
               OP_AND:  ALUop = 2'b10;
               OP_MVN:  ALUop = 2'b11;
               default: ALUop = 2'b00;
            endcase
            // Single-operand ops force the A input to zero
            asel = (cur_op == OP_MOVS) || (cur_op == OP_MVN);
            done = (cur_op == OP_CMP);
         end
         S_WIMM: begin
            vsel     = 1'b1;
            write    = 1'b1;
            writenum = cur_rd;
            done     = 1'b1;
         end
         S_WREG: begin
            write    = 1'b1;
            writenum = cur_rd;
            done     = 1'b1;
         end
         S_ERR:   err = 1'b1;
         default: ;
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_datapath_sequencer.sv
// Directed bench for datapath_sequencer with a behavioural register-file/ALU model.
`default_nettype none

module tb_datapath_sequencer;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [2:0]  cmd_op = '0;
   logic [2:0]  cmd_rd = '0;
   logic [2:0]  cmd_rn = '0;
   logic [2:0]  cmd_rm = '0;
   logic [1:0]  cmd_sh = '0;
   logic [15:0] cmd_imm = '0;
   logic        done, err;
   logic [15:0] datapath_in;
   logic [2:0]  writenum, readnum;
   logic        write, vsel, asel, bsel, loada, loadb, loadc, loads;
   logic [1:0]  ALUop, shift;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   datapath_sequencer #(.DATA_W(16), .RADDR_W(3)) dut (
      .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rn(cmd_rn), .cmd_rm(cmd_rm),
      .cmd_sh(cmd_sh), .cmd_imm(cmd_imm), .done(done), .err(err),
      .datapath_in(datapath_in), .writenum(writenum), .readnum(readnum),
      .write(write), .vsel(vsel), .asel(asel), .bsel(bsel), .loada(loada),
      .loadb(loadb), .loadc(loadc), .loads(loads), .ALUop(ALUop), .shift(shift)
   );

   // Datapath model: register file, A/B/C latches, shifter, ALU, Z flag
   logic [15:0] R [8];
   logic [15:0] A, B, C;
   logic        Z;
   logic [15:0] sh_out, ain, bin, alu;

   always_comb begin
      case (shift)
         2'b01:   sh_out = {B[14:0], 1'b0};
         2'b10:   sh_out = {1'b0, B[15:1]};
         2'b11:   sh_out = {B[15], B[15:1]};
         default: sh_out = B;
      endcase
      ain = asel ? 16'd0 : A;
      bin = bsel ? {11'd0, datapath_in[4:0]} : sh_out;
      case (ALUop)
         2'b01:   alu = ain - bin;
         2'b10:   alu = ain & bin;
         2'b11:   alu = ~bin;
         default: alu = ain + bin;
      endcase
   end

   int wcnt = 0, dcnt = 0, both_cnt = 0, hold_viol = 0;

   always @(posedge clk) begin
      if (write) R[writenum] <= vsel ? datapath_in : C;
      if (loada) A <= R[readnum];
      if (loadb) B <= R[readnum];
      if (loadc) C <= alu;
      if (loads) Z <= (alu == 16'd0);
      if (write) wcnt++;
      if (done) dcnt++;
      if (done && err) both_cnt++;
      if (!loadc && (shift != 2'b00 || ALUop != 2'b00)) hold_viol++;
   end

   // Issue one command and measure cycles from accept edge to done/err
   task automatic run_cmd(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rn,
                          input logic [2:0] rm, input logic [1:0] sh, input logic [15:0] imm,
                          output int lat, output logic got_err);
      int n;
      cmd_op = op; cmd_rd = rd; cmd_rn = rn; cmd_rm = rm; cmd_sh = sh; cmd_imm = imm;
      cmd_valid = 1'b1;
      n = 0;
      while (!cmd_ready && n < 20) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      lat = 1;
      while (!(done || err) && lat < 20) begin @(posedge clk); #1; lat++; end
      got_err = err;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      logic [33:0] ctl;
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      ctl = {done, err, datapath_in, writenum, readnum, write, vsel, asel, bsel,
             loada, loadb, loadc, loads};
      total++;
      if (ctl !== 34'd0 || ALUop !== 2'b00 || shift !== 2'b00) begin
         bad++; $display("FAIL reset_outputs got=%h alu=%b sh=%b exp=0", ctl, ALUop, shift);
      end
      total++;
      if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
      reset_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_movi_movs();
      int lat; logic e;
      run_cmd(3'b000, 3'd2, 3'd0, 3'd0, 2'b00, 16'd32, lat, e);
      total++;
      if (lat !== 1) begin bad++; $display("FAIL movi_latency got=%0d exp=1", lat); end
      total++;
      if (datapath_in !== 16'd32) begin bad++; $display("FAIL movi_datapath_in got=%0d exp=32", datapath_in); end
      run_cmd(3'b001, 3'd3, 3'd0, 3'd2, 2'b00, 16'd0, lat, e);
      total++;
      if (lat !== 3) begin bad++; $display("FAIL movs_latency got=%0d exp=3", lat); end
      total++;
      if (R[3] !== 16'd32) begin bad++; $display("FAIL movs_r3 got=%0d exp=32", R[3]); end
   endtask

   task automatic test_add();
      int lat; logic e;
      run_cmd(3'b000, 3'd0, 3'd0, 3'd0, 2'b00, 16'd7, lat, e);
      run_cmd(3'b000, 3'd1, 3'd0, 3'd0, 2'b00, 16'd2, lat, e);
      run_cmd(3'b010, 3'd2, 3'd1, 3'd0, 2'b01, 16'd0, lat, e);
      total++;
      if (lat !== 4) begin bad++; $display("FAIL add_latency got=%0d exp=4", lat); end
      total++;
      if (C !== 16'd16) begin bad++; $display("FAIL add_c got=%0d exp=16", C); end
      total++;
      if (R[2] !== 16'd16) begin bad++; $display("FAIL add_r2 got=%0d exp=16", R[2]); end
   endtask

   task automatic test_cmp();
      int lat, w0; logic e;
      run_cmd(3'b000, 3'd5, 3'd0, 3'd0, 2'b00, 16'd74, lat, e);
      run_cmd(3'b000, 3'd2, 3'd0, 3'd0, 2'b00, 16'd16, lat, e);
      w0 = wcnt;
      run_cmd(3'b011, 3'd0, 3'd5, 3'd2, 2'b10, 16'd0, lat, e);
      total++;
      if (lat !== 3) begin bad++; $display("FAIL cmp_latency got=%0d exp=3", lat); end
      total++;
      if (C !== 16'd66 || Z !== 1'b0) begin bad++; $display("FAIL cmp_result got=%0d/%b exp=66/0", C, Z); end
      total++;
      if (wcnt !== w0) begin bad++; $display("FAIL cmp_nowrite got=%0d exp=0", wcnt - w0); end
   endtask

   task automatic test_mvn_illegal();
      int lat, w0, d0; logic e;
      run_cmd(3'b101, 3'd6, 3'd0, 3'd0, 2'b00, 16'd0, lat, e);
      total++;
      if (lat !== 3 || R[6] !== 16'hFFF8) begin
         bad++; $display("FAIL mvn got=lat%0d/%h exp=lat3/fff8", lat, R[6]);
      end
      w0 = wcnt; d0 = dcnt;
      run_cmd(3'b110, 3'd4, 3'd0, 3'd0, 2'b00, 16'd0, lat, e);
      total++;
      if (lat !== 1 || e !== 1'b1) begin bad++; $display("FAIL illegal_err got=lat%0d/err%b exp=lat1/err1", lat, e); end
      total++;
      if (wcnt !== w0 || dcnt !== d0) begin
         bad++; $display("FAIL illegal_quiet got=writes%0d/dones%0d exp=0/0", wcnt - w0, dcnt - d0);
      end
      total++;
      if (cmd_ready !== 1'b1 || err !== 1'b0) begin bad++; $display("FAIL illegal_idle got=%b%b exp=10", cmd_ready, err); end
   endtask

   task automatic test_reset_midcmd();
      int n, w0, d0, lat; logic e;
      cmd_op = 3'b010; cmd_rd = 3'd2; cmd_rn = 3'd1; cmd_rm = 3'd0; cmd_sh = 2'b00;
      cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      n = 0;
      while (!loadb && n < 10) begin @(posedge clk); #1; n++; end
      total++;
      if (loadb !== 1'b1) begin bad++; $display("FAIL midreset_reach_getb got=%b exp=1", loadb); end
      w0 = wcnt; d0 = dcnt;
      reset_n = 1'b0;
      #1;
      total++;
      if ({done, err, write, loada, loadb, loadc, loads, readnum, ALUop, shift} !== 16'd0 || cmd_ready !== 1'b1) begin
         bad++; $display("FAIL midreset_outputs got=%b/%b exp=0/1", {done, err, write, loadb, readnum}, cmd_ready);
      end
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
      total++;
      if (wcnt !== w0 || dcnt !== d0 || R[2] !== 16'd16) begin
         bad++; $display("FAIL midreset_abort got=w%0d/d%0d/r2=%0d exp=0/0/16", wcnt - w0, dcnt - d0, R[2]);
      end
      run_cmd(3'b000, 3'd3, 3'd0, 3'd0, 2'b00, 16'd5, lat, e);
      total++;
      if (lat !== 1 || R[3] !== 16'd5) begin bad++; $display("FAIL midreset_movi got=lat%0d/%0d exp=1/5", lat, R[3]); end
   endtask

   task automatic test_back_to_back();
      int d1, d2; logic ready_busy, go, exp_ready;
`ifdef DATAPATH_SEQ_CMDBUF_EN
      exp_ready = 1'b1;
`else
      exp_ready = 1'b0;
`endif
      d1 = 0; d2 = 0; ready_busy = 1'bx;
      cmd_op = 3'b010; cmd_rd = 3'd4; cmd_rn = 3'd1; cmd_rm = 3'd0; cmd_sh = 2'b00;
      cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_op = 3'b000; cmd_rd = 3'd7; cmd_imm = 16'h1234;
      for (int cyc = 1; cyc <= 30; cyc++) begin
         if (cyc == 1) ready_busy = cmd_ready;
         if (done) begin
            if (d1 == 0) d1 = cyc;
            else if (d2 == 0) d2 = cyc;
         end
         if (d2 != 0) break;
         go = cmd_valid & cmd_ready;
         @(posedge clk); #1;
         if (go) cmd_valid = 1'b0;
      end
      cmd_valid = 1'b0;
      @(posedge clk); #1;
      total++;
      if (ready_busy !== exp_ready) begin bad++; $display("FAIL b2b_ready_busy got=%b exp=%b", ready_busy, exp_ready); end
      total++;
      if (d1 !== 4 || d2 !== 6) begin bad++; $display("FAIL b2b_done_cycles got=%0d,%0d exp=4,6", d1, d2); end
      total++;
      if (R[4] !== 16'd9 || R[7] !== 16'h1234) begin
         bad++; $display("FAIL b2b_regs got=%h,%h exp=0009,1234", R[4], R[7]);
      end
      total++;
      if (both_cnt !== 0 || hold_viol !== 0) begin
         bad++; $display("FAIL global_invariants got=both%0d/hold%0d exp=0/0", both_cnt, hold_viol);
      end
   endtask

   initial begin
      test_reset();
      test_movi_movs();
      test_add();
      test_cmp();
      test_mvn_illegal();
      test_reset_midcmd();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
